// File: rtl/cordic_div_pkg.sv
// Shared definitions for the linear-vectoring CORDIC divider.
//   state_t   : controller states (IDLE, RUN, DONE)
//   RW        : residual / divisor register width (18-bit signed)
//   FW        : quotient fraction width (Q1.14)
//   ZW        : internal quotient accumulator width (17-bit signed)
//   IW        : iteration counter width
//   sat_value : saturated quotient returned on overflow
package cordic_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int DW = 16;
   localparam int RW = 18;
   localparam int FW = 14;
   localparam int ZW = FW + 3;
   localparam int IW = 5;

   // Largest positive or most negative Q1.14 code, sign-extended to ZW bits.
   function automatic logic [ZW-1:0] sat_value(input logic pos);
      return pos ? {1'b0, 16'h7FFF} : {1'b1, 16'h8000};
   endfunction

endpackage

// File: rtl/cordic_div_stage.sv
// One combinational linear-vectoring CORDIC iteration.
//   r      : current residual (signed, RW bits)
//   xr     : divisor (signed, RW bits)
//   z      : quotient accumulated so far (signed, ZW bits, Q14)
//   i      : iteration index; step weight is 2^(FW-i) in Q14
//   r_next : residual for the next iteration, 2*(r - d*xr)
//   z_next : quotient after adding d * step
module cordic_div_stage
   import cordic_div_pkg::*;
(
   input  logic signed [RW-1:0] r,
   input  logic signed [RW-1:0] xr,
   input  logic signed [ZW-1:0] z,
   input  logic        [IW-1:0] i,
   output logic signed [RW-1:0] r_next,
   output logic signed [ZW-1:0] z_next
);

   logic signed [RW-1:0] diff;
   logic signed [ZW-1:0] step;

   always_comb begin
      step   = ZW'(1) << (IW'(FW) - i);
      diff   = r;
      z_next = z;
      // A zero residual means the quotient is already exact: d = 0.
      if (r != '0) begin
         if (r[RW-1] == xr[RW-1]) begin
            diff   = r - xr;
            z_next = z + step;
         end else begin
            diff   = r + xr;
            z_next = z - step;
         end
      end
      r_next = diff <<< 1;
   end

endmodule

// File: rtl/cordic_div16.sv
// 16-bit signed divider z = y / x (Q1.14 result, range [-2, 2)) using a
// linear-vectoring CORDIC, one iteration per clock.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid, in_ready  : operand handshake
//   x_in, y_in          : signed divisor and dividend
//   out_valid, out_ready: result handshake
//   z_out               : signed Q1.14 quotient
//   overflow            : x == 0 or |y| >= 2|x| (z_out saturated)
module cordic_div16
   import cordic_div_pkg::*;
#(
   parameter int ITER = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   x_in,
   input  logic [15:0]   y_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   z_out,
   output logic          overflow
);

   state_t               state;
   logic signed [RW-1:0] r;
   logic signed [RW-1:0] xr;
   logic signed [ZW-1:0] z;
   logic        [IW-1:0] i;
   logic                 sat_pos;

   logic signed [RW-1:0] r_next;
   logic signed [ZW-1:0] z_next;
   logic signed [RW-1:0] y_ext;
   logic signed [RW-1:0] x_ext;
   logic signed [RW-1:0] y_abs;
   logic signed [RW-1:0] x_dbl;
   logic                 ovf_in;

   assign y_ext = {{(RW-DW){y_in[DW-1]}}, y_in};
   assign x_ext = {{(RW-DW){x_in[DW-1]}}, x_in};

   always_comb begin
      y_abs  = y_ext[RW-1] ? -y_ext : y_ext;
      x_dbl  = (x_ext[RW-1] ? -x_ext : x_ext) <<< 1;
      ovf_in = (x_in == '0) || (y_abs >= x_dbl);
   end

   cordic_div_stage u_stage (
      .r      (r),
      .xr     (xr),
      .z      (z),
      .i      (i),
      .r_next (r_next),
      .z_next (z_next)
   );

   assign z_out = z[DW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         sat_pos   <= 1'b0;
         r         <= '0;
         xr        <= '0;
         z         <= '0;
         i         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  r        <= y_ext;
                  xr       <= x_ext;
                  z        <= '0;
                  i        <= '0;
                  overflow <= ovf_in;
                  sat_pos  <= (y_in[DW-1] == x_in[DW-1]);
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               // ITER iteration edges, then one finishing edge that applies
               // saturation and raises out_valid (ITER+1 edges after accept).
               if (i == IW'(ITER)) begin
                  if (overflow) begin
                     z <= sat_value(sat_pos);
                  end
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  r <= r_next;
                  z <= z_next;
                  i <= i + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_div16.sv
// Scoreboard bench for cordic_div16: stimulus pushes reference quotients,
// a monitor pops and compares on every output handshake.
module tb_cordic_div16;

   localparam int ITER = 15;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] x_in      = '0;
   logic [15:0] y_in      = '0;
   logic        in_ready;
   logic        out_valid;
   logic        overflow;
   logic [15:0] z_out;

   typedef struct {
      int y;
      int x;
      int ez;
      bit eo;
      bit exact;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   checks     = 0;
   int   fails      = 0;
   int   cyc        = 0;
   bit   rand_ready = 1'b0;
   bit   prev_valid = 1'b0;

   cordic_div16 #(.ITER(ITER)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z_out     (z_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Random consumer backpressure when enabled.
   initial forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = ($urandom_range(3) != 0);
   end

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Reference: real-valued quotient rounded to nearest Q14 code.
   function automatic void model(input int y, input int x, output int ez, output bit eo);
      int  ay;
      int  ax;
      real q;
      ay = (y < 0) ? -y : y;
      ax = (x < 0) ? -x : x;
      eo = (x == 0) || (ay >= 2 * ax);
      ez = 0;
      if (eo) begin
         ez = ((y < 0) == (x < 0)) ? 32767 : -32768;
      end else begin
         q  = real'(y) * 16384.0 / real'(x);
         ez = (q >= 0.0) ? int'($floor(q + 0.5)) : -int'($floor(0.5 - q));
      end
   endfunction

   task automatic send(input logic [15:0] y, input logic [15:0] x, input bit exact);
      int unsigned g = 0;
      exp_t        e;
      int          ez;
      bit          eo;
      while (!in_ready && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (!in_ready) begin
         checks++;
         fails++;
         $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
         return;
      end
      y_in     = y;
      x_in     = x;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e.y      = int'($signed(y));
      e.x      = int'($signed(x));
      model(e.y, e.x, ez, eo);
      e.ez     = ez;
      e.eo     = eo;
      e.exact  = exact;
      e.acc    = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      int unsigned g = 0;
      while (sb.size() != 0 && g < 400) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk("drain_pending", sb.size(), 0);
   endtask

   // Monitor: latency on each rising out_valid, value on each handshake.
   always @(negedge clk) begin
      exp_t e;
      int   dz;
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_result: out_valid=1 with no pending operation, z_out=%h", z_out);
            end else begin
               chk("latency", cyc - sb[0].acc, ITER + 1);
            end
         end
         if (out_valid && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("overflow", int'(overflow), int'(e.eo));
            if (e.exact || e.eo) begin
               chk("z_exact", int'($signed(z_out)), e.ez);
            end else begin
               dz = int'($signed(z_out)) - e.ez;
               if (dz < 0) dz = -dz;
               checks++;
               if (dz > 1) begin
                  fails++;
                  $display("FAIL z_tol: y=%0d x=%0d got %0d expected %0d +/-1",
                           e.y, e.x, int'($signed(z_out)), e.ez);
               end
            end
         end
         prev_valid = out_valid;
      end
   end

   initial begin
      int unsigned g;
      bit          seen;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_z_out", int'(z_out), 0);
      chk("rst_overflow", int'(overflow), 0);

      // Directed quotients, overflow cases and range boundaries.
      send(16'd1, 16'd2, 1'b1);
      send(16'd3, 16'd4, 1'b1);
      send(16'hFFFD, 16'd4, 1'b1);
      send(16'd3, 16'hFFFC, 1'b1);
      send(16'd5, 16'd0, 1'b1);
      send(16'd8, 16'hFFFC, 1'b1);
      send(16'd0, 16'd0, 1'b1);
      send(16'hFFFB, 16'd0, 1'b1);
      send(16'h8000, 16'h8000, 1'b0);
      send(16'h7FFF, 16'h4000, 1'b0);
      send(16'h8000, 16'h4000, 1'b0);
      send(16'h8001, 16'h4000, 1'b0);
      send(16'd1, 16'h8000, 1'b0);
      send(16'h7FFF, 16'h7FFF, 1'b0);
      send(16'd0, 16'd7, 1'b1);
      wait_drain();

      // Held result under backpressure; in_valid noise is ignored.
      out_ready = 1'b0;
      send(16'd3, 16'd4, 1'b1);
      g = 0;
      while (!out_valid && g < 40) begin
         in_valid = g[0];
         y_in     = 16'($urandom);
         x_in     = 16'($urandom);
         @(posedge clk);
         #1;
         g++;
      end
      chk("stall_valid_reached", int'(out_valid), 1);
      repeat (10) begin
         @(negedge clk);
         chk("stall_z_hold", int'(z_out), 32'h3000);
         chk("stall_in_ready", int'(in_ready), 0);
         chk("stall_out_valid", int'(out_valid), 1);
         @(posedge clk);
         #1;
         in_valid = 1'($urandom_range(1));
         y_in     = 16'($urandom);
         x_in     = 16'($urandom);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_in_ready", int'(in_ready), 1);
      chk("release_out_valid", int'(out_valid), 0);
      send(16'd1, 16'd2, 1'b1);
      wait_drain();

      // Abort mid-iteration with reset.
      rand_ready = 1'b1;
      send(16'd5, 16'd7, 1'b0);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_z_out", int'(z_out), 0);
      chk("abort_overflow", int'(overflow), 0);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_result", int'(seen), 0);
      send(16'd3, 16'd4, 1'b1);
      wait_drain();

      // Random operand pairs with random backpressure.
      for (int n = 0; n < 2000; n++) begin
         send(16'($urandom), 16'($urandom), 1'b0);
      end
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
